// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// matrix_pkg : shared types and helpers for the 8x8 LED matrix scan controller
// Rev 1.0
// ============================================================================
package matrix_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int ROW_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    function automatic logic [7:0] pin_off(input bit active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    // Converts a 1-means-asserted mask into pin levels for the given polarity.
    function automatic logic [7:0] pin_drive(input bit active_low, input logic [7:0] on_mask);
        return active_low ? ~on_mask : on_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_frame_buffer.sv
`default_nettype none
// ============================================================================
// matrix_frame_buffer : two 8x8 pixel planes, one write port, one read port
// Rev 1.0
// ============================================================================
module matrix_frame_buffer
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic             i_wr_sel,
    input  logic [ROW_W-1:0] i_wr_row,
    input  logic [COLS-1:0]  i_wr_data,
    input  logic             i_rd_sel,
    input  logic [ROW_W-1:0] i_rd_row,
    output logic [COLS-1:0]  o_rd_data
);

    logic [COLS-1:0] r_mem [2][ROWS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    r_mem[b][r] <= '0;
                end
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_sel][i_wr_row] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_sel][i_rd_row];

endmodule
`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// matrix_scan_ctrl : blanked row-scan sequencer with tear-free double buffer
// Rev 1.0
// ============================================================================
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int DWELL_CYCLES   = 500,
    parameter int BLANK_CYCLES   = 25,
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter bit COL_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic [2:0]       i_brightness,
    input  logic             i_wr_en,
    input  logic [ROW_W-1:0] i_wr_row,
    input  logic [COLS-1:0]  i_wr_data,
    input  logic             i_swap_req,
    output logic             o_swap_pending,
    output logic             o_swap_done,
    output logic             o_frame_start,
    output logic [ROW_W-1:0] o_row_idx,
    output logic [ROWS-1:0]  o_row_out,
    output logic [COLS-1:0]  o_col_out
);

    localparam int c_cnt_max = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);
    localparam logic [ROW_W-1:0]   c_last_row   = ROW_W'(ROWS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] r_on_time;
    logic [c_cnt_w-1:0] w_on_time;
    logic [ROW_W-1:0]   r_row_idx;
    logic               r_front_sel;
    logic               r_swap_pending;
    logic [ROWS-1:0]    r_row_out;
    logic [COLS-1:0]    r_col_out;
    logic [COLS-1:0]    w_front_row;
    logic [ROWS-1:0]    w_row_mask;
    logic [ROWS-1:0]    w_row_next;
    logic [COLS-1:0]    w_col_next;
    logic               w_last_drive;
    logic               w_commit;
    logic               w_frame_start;

    matrix_frame_buffer u_fb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (i_wr_en),
        .i_wr_sel  (~r_front_sel),
        .i_wr_row  (i_wr_row),
        .i_wr_data (i_wr_data),
        .i_rd_sel  (r_front_sel),
        .i_rd_row  (r_row_idx),
        .o_rd_data (w_front_row)
    );

    assign w_last_drive = (r_state == ST_DRIVE) && (r_cnt == c_dwell_last);
    assign w_on_time    = c_cnt_w'(((int'(i_brightness) + 1) * DWELL_CYCLES) >> 3);

    // A request arriving on the commit cycle itself rides along with that commit.
    assign w_commit = ((r_state == ST_IDLE) && r_swap_pending) ||
                      (w_last_drive && (r_row_idx == c_last_row) && (r_swap_pending || i_swap_req));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) w_state_next = ST_BLANK;
            end
            ST_BLANK: begin
                if (!i_enable)                  w_state_next = ST_IDLE;
                else if (r_cnt == c_blank_last) w_state_next = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (!i_enable)         w_state_next = ST_IDLE;
                else if (w_last_drive) w_state_next = ST_BLANK;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_frame_start = (r_state == ST_BLANK) && (r_cnt == '0) && (r_row_idx == '0);
        w_row_mask    = '0;
        w_row_mask[r_row_idx] = 1'b1;
        w_row_next    = pin_off(ROW_ACTIVE_LOW);
        w_col_next    = pin_off(COL_ACTIVE_LOW);
        // Gating on i_enable lets the pins go dark in the same cycle the FSM drops to IDLE.
        if (i_enable && (r_state == ST_DRIVE)) begin
            w_row_next = pin_drive(ROW_ACTIVE_LOW, w_row_mask);
            if (r_cnt < r_on_time) begin
                w_col_next = pin_drive(COL_ACTIVE_LOW, w_front_row);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_row_idx <= '0;
            r_on_time <= '0;
        end else begin
            if ((w_state_next != r_state) || (r_state == ST_IDLE)) r_cnt <= '0;
            else                                                    r_cnt <= r_cnt + 1'b1;

            if (w_state_next == ST_IDLE)                                r_row_idx <= '0;
            else if ((r_state == ST_DRIVE) && (w_state_next == ST_BLANK)) r_row_idx <= r_row_idx + 1'b1;

            if ((r_state == ST_BLANK) && (w_state_next == ST_DRIVE)) r_on_time <= w_on_time;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front_sel    <= 1'b0;
            r_swap_pending <= 1'b0;
            r_row_out      <= pin_off(ROW_ACTIVE_LOW);
            r_col_out      <= pin_off(COL_ACTIVE_LOW);
        end else begin
            r_front_sel <= r_front_sel ^ w_commit;
            if (w_commit)        r_swap_pending <= 1'b0;
            else if (i_swap_req) r_swap_pending <= 1'b1;
            r_row_out <= w_row_next;
            r_col_out <= w_col_next;
        end
    end

    assign o_swap_pending = r_swap_pending;
    assign o_swap_done    = w_commit;
    assign o_frame_start  = w_frame_start;
    assign o_row_idx      = r_row_idx;
    assign o_row_out      = r_row_out;
    assign o_col_out      = r_col_out;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_matrix_scan_ctrl : directed bench, DWELL=8 BLANK=2, active-low pins
// Rev 1.0
// ============================================================================
module tb_matrix_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [2:0] brightness;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       swap_pending;
    logic       swap_done;
    logic       frame_start;
    logic [2:0] row_idx;
    logic [7:0] row_out;
    logic [7:0] col_out;

    always #5 clk = ~clk;

    matrix_scan_ctrl #(
        .DWELL_CYCLES   (8),
        .BLANK_CYCLES   (2),
        .ROW_ACTIVE_LOW (1'b1),
        .COL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (enable),
        .i_brightness   (brightness),
        .i_wr_en        (wr_en),
        .i_wr_row       (wr_row),
        .i_wr_data      (wr_data),
        .i_swap_req     (swap_req),
        .o_swap_pending (swap_pending),
        .o_swap_done    (swap_done),
        .o_frame_start  (frame_start),
        .o_row_idx      (row_idx),
        .o_row_out      (row_out),
        .o_col_out      (col_out)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         o;
    logic [7:0] m_front [8];
    int         m_on;
    int         pend_lo;
    int         pend_hi;
    int         done_at;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected pins from the offset since frame_start: a row's 8 lit cycles start 3 cycles in.
    task automatic check_cycle();
        int         r;
        int         k;
        logic [7:0] er;
        logic [7:0] ec;
        er = 8'hFF;
        ec = 8'hFF;
        if (o >= 3 && ((o - 3) % 10) < 8) begin
            r  = ((o - 3) / 10) % 8;
            k  = (o - 3) % 10;
            er = ~(8'h01 << r);
            if (k < m_on) ec = ~m_front[r];
        end
        check_eq($sformatf("row_out@%0d", o), row_out, er);
        check_eq($sformatf("col_out@%0d", o), col_out, ec);
        check_eq($sformatf("row_idx@%0d", o), row_idx, (o / 10) % 8);
        check_eq($sformatf("frame_start@%0d", o), frame_start, (o % 80) == 0);
        check_eq($sformatf("swap_done@%0d", o), swap_done, o == done_at);
        check_eq($sformatf("swap_pending@%0d", o), swap_pending, (o >= pend_lo) && (o <= pend_hi));
    endtask

    task automatic run_to(input int t);
        while (o < t) begin
            @(negedge clk);
            o++;
            check_cycle();
        end
    endtask

    task automatic wait_fs(input string tag);
        int n = 0;
        while (frame_start !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, n, 1);
    endtask

    task automatic check_dark(input string tag, input logic exp_done, input logic exp_pend);
        check_eq({tag, "_row"},   row_out, 8'hFF);
        check_eq({tag, "_col"},   col_out, 8'hFF);
        check_eq({tag, "_idx"},   row_idx, 3'd0);
        check_eq({tag, "_fs"},    frame_start, 1'b0);
        check_eq({tag, "_done"},  swap_done, exp_done);
        check_eq({tag, "_pend"},  swap_pending, exp_pend);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; brightness = 3'd7;
        wr_en = 1'b0; wr_row = 3'd0; wr_data = 8'h00; swap_req = 1'b0;
        for (int i = 0; i < 8; i++) m_front[i] = 8'h00;
        m_on = 8; pend_lo = -1; pend_hi = -2; done_at = -1; o = 0;

        repeat (3) begin
            @(negedge clk);
            check_dark("reset", 1'b0, 1'b0);
        end
        rst_n = 1'b1;

        wait_fs("fs_after_reset");
        o = 0;
        check_cycle();

        // Frame 0: load back buffer, request swap mid-row 2, repeat request, write on commit cycle.
        run_to(5);  wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'h81;
        run_to(6);  wr_en = 1'b0;
        run_to(25); swap_req = 1'b1; pend_lo = 26; pend_hi = 79; done_at = 79;
        run_to(26); swap_req = 1'b0;
        run_to(45); swap_req = 1'b1;
        run_to(46); swap_req = 1'b0;
        run_to(79); wr_en = 1'b1; wr_row = 3'd5; wr_data = 8'h3C;
        run_to(80); wr_en = 1'b0;
        m_front[3] = 8'h81;
        m_front[5] = 8'h3C;

        run_to(160); brightness = 3'd1; m_on = 2;
        run_to(240); brightness = 3'd0; m_on = 1;

        // Frame 3: fill the current back buffer, request swap, then disable mid row 5.
        run_to(250); wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'hAA;
        run_to(251); wr_en = 1'b0;
        run_to(290); swap_req = 1'b1; pend_lo = 291; pend_hi = 400;
        run_to(291); swap_req = 1'b0;
        run_to(296); enable = 1'b0;
        @(negedge clk); check_dark("disable1", 1'b1, 1'b1);
        @(negedge clk); check_dark("disable2", 1'b0, 1'b0);
        @(negedge clk); check_dark("disable3", 1'b0, 1'b0);
        enable = 1'b1;

        wait_fs("fs_after_reenable");
        o = 0; pend_lo = -1; pend_hi = -2; done_at = -1;
        for (int i = 0; i < 8; i++) m_front[i] = 8'h00;
        m_front[0] = 8'hAA;
        check_cycle();

        run_to(40); swap_req = 1'b1; pend_lo = 41; pend_hi = 1000;
        run_to(41); swap_req = 1'b0;
        run_to(50); rst_n = 1'b0;
        #1;
        check_dark("midreset_async", 1'b0, 1'b0);
        @(negedge clk); check_dark("midreset_hold", 1'b0, 1'b0);
        rst_n = 1'b1;

        wait_fs("fs_after_midreset");
        o = 0; pend_lo = -1; pend_hi = -2; done_at = -1;
        for (int i = 0; i < 8; i++) m_front[i] = 8'h00;
        check_cycle();
        run_to(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
